// File: rtl/pwm_burst_detector.sv
// Carrier lock detector for the ultrasonic receiver: measures the period and high time of the
// synchronized comparator output and declares lock after MIN_CYCLES consecutive in-tolerance periods.
module pwm_burst_detector #(
    parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
    parameter int TOLERANCE              = 125,
    parameter int MIN_CYCLES             = 4,
    parameter int TIMEOUT                = 5000,
    localparam int W                     = $clog2(TIMEOUT + 1)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         sig_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] high_out,
    output logic         meas_valid_out,
    output logic         locked_out,
    output logic         lost_out
);

    localparam int VW = $clog2(MIN_CYCLES + 1);
    localparam logic [W-1:0]          TO_W  = W'(TIMEOUT);
    localparam logic signed [W+1:0]   NOM_S = (W+2)'(PERIOD_IN_CLOCK_CYCLES);
    localparam logic signed [W+1:0]   TOL_S = (W+2)'(TOLERANCE);
    localparam logic [VW-1:0]         LAST_V = VW'(MIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [VW-1:0] valid_cnt, valid_nxt;

    logic          sig_p0, sig_p1, sig_p2;
    logic          rise, fall, timeout, in_tol;
    logic [W-1:0]  since_cnt, high_cnt;
    logic          high_frz;
    logic [W-1:0]  period_p3, high_p3;
    logic          vld_p3, lost_p3;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v >= TO_W) ? TO_W : v + W'(1);
    endfunction

    function automatic logic within_tol(input logic [W-1:0] p);
        logic signed [W+1:0] diff;
        diff = $signed({2'b00, p}) - NOM_S;
        return (diff <= TOL_S) && (diff >= -TOL_S);
    endfunction

    assign rise    = sig_p1 & ~sig_p2;
    assign fall    = ~sig_p1 & sig_p2;
    assign timeout = (since_cnt == TO_W);
    assign in_tol  = within_tol(since_cnt);

    // p0/p1: metastability synchronizer, p2: edge-detect delay, p3: published measurement
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sig_p0    <= 1'b0;
            sig_p1    <= 1'b0;
            sig_p2    <= 1'b0;
            since_cnt <= '0;
            high_cnt  <= '0;
            high_frz  <= 1'b0;
            period_p3 <= '0;
            high_p3   <= '0;
            vld_p3    <= 1'b0;
            lost_p3   <= 1'b0;
        end else begin
            sig_p0  <= sig_in;
            sig_p1  <= sig_p0;
            sig_p2  <= sig_p1;
            vld_p3  <= 1'b0;
            lost_p3 <= (state == LOCKED) && timeout && !rise;
            if (rise) begin
                since_cnt <= W'(1);
                high_cnt  <= W'(1);
                high_frz  <= 1'b0;
                if (state != IDLE) begin
                    period_p3 <= since_cnt;
                    high_p3   <= high_cnt;
                    vld_p3    <= 1'b1;
                end
            end else begin
                since_cnt <= sat_inc(since_cnt);
                if (fall)
                    high_frz <= 1'b1;
                else if (!high_frz)
                    high_cnt <= sat_inc(high_cnt);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            valid_cnt <= '0;
        end else begin
            state     <= state_nxt;
            valid_cnt <= valid_nxt;
        end
    end

    // A rising edge takes priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ARMED;
                    valid_nxt = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    if (!in_tol) begin
                        valid_nxt = '0;
                    end else if (valid_cnt == LAST_V) begin
                        state_nxt = LOCKED;
                        valid_nxt = '0;
                    end else begin
                        valid_nxt = valid_cnt + VW'(1);
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    valid_nxt = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!in_tol) begin
                        state_nxt = ARMED;
                        valid_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    valid_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = '0;
            end
        endcase
    end

    always_comb begin
        locked_out     = (state == LOCKED);
        lost_out       = lost_p3;
        meas_valid_out = vld_p3;
        period_out     = period_p3;
        high_out       = high_p3;
    end

endmodule
